lab2_proc_int_div_unit: RTL and testbench
=========================================

Name: lab2_proc_int_div_unit

Overview:
Iterative integer divide/remainder unit for the TinyRV2 pipelined processor. It implements the RISC-V M divide ops DIV, DIVU, REM and REMU. It is the responder to the X-stage request: the pipeline issues a val/rdy request and stalls until the val/rdy response returns. Single-cycle ALU ops stay in the ALU; this unit holds multi-cycle state.

Parameters:
p_nbits, 32, operand/result width; iteration count equals p_nbits.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_val  input  1  request valid
req_rdy  output  1  unit can accept request
req_fn  input  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
req_a  input  p_nbits  dividend (rs1)
req_b  input  p_nbits  divisor (rs2)
resp_val  output  1  result valid
resp_rdy  input  1  consumer accepts result
resp_msg  output  p_nbits  quotient or remainder

Behaviour:
- FSM states: IDLE, CALC, DONE. Reset value is IDLE. After the reset edge: req_rdy=1, resp_val=0, resp_msg=0.
- IDLE: req_rdy=1, resp_val=0. On req_val&&req_rdy, latch fn, operand magnitudes (abs for DIV/REM, raw for DIVU/REMU) and sign flags, clear the remainder register, load counter=p_nbits, then go to CALC.
- CALC: req_rdy=0, resp_val=0. Each cycle performs one restoring step:
  - shift {rem,quo} left 1
  - trial = rem - divisor (p_nbits+1 bits wide)
  - if trial is non-negative, rem=trial and quo[0]=1
  - decrement counter; when counter reaches 1 on this cycle, go to DONE.
  - CALC lasts exactly p_nbits cycles.
- DONE: resp_val=1, req_rdy=0. resp_msg is registered and stable while resp_val&&!resp_rdy. On resp_rdy, go to IDLE. No back-to-back accept in the DONE cycle.
- Latency: request accepted at edge N gives resp_val high in the cycle after edge N+p_nbits (34 cycles to DONE entry for p_nbits=32, counting the accept cycle).
- Sign fix-up:
  - DIV quotient is negated if the signs of a and b differ.
  - REM remainder takes the sign of the dividend.
- Special cases are computed by the iteration naturally or forced at DONE entry. Results must be:
  - b==0: DIV/DIVU returns all-ones; REM/REMU returns a.
  - DIV with a=most-negative and b=-1: returns a. REM for the same operands returns 0.
- Reset asserted in any state, including mid-CALC or DONE with a pending response: next state is IDLE and the in-flight result is discarded. No response is ever emitted for it.
- req_fn, req_a and req_b are ignored unless req_val&&req_rdy.

Optional Feature:
LAB2_PROC_INT_DIV_FAST_EN
- Defined: at accept, if b==0, the DIV overflow case applies, or |a| < |b| (unsigned compare of magnitudes), the FSM goes IDLE->DONE directly with the final result. Latency is then 1 cycle to resp_val. All other requests still take p_nbits CALC cycles.
- Undefined: every request takes the full p_nbits CALC cycles. Results are bit-identical in both builds.

Decomposition:
- Shared package lab2_proc_div_pkg holds:
  - fn encodings DIV_FN_DIV/DIVU/REM/REMU
  - state enum IDLE/CALC/DONE
  - the counter width constant $clog2(p_nbits+1)
- One natural sub-module: lab2_proc_int_div_dpath, containing the operand/remainder/quotient registers, subtractor, counter and sign fix-up. The top level holds the FSM and val/rdy logic.

Test Plan:
- DIVU a=100 b=7 -> resp_msg=14 after 32 CALC cycles; REMU same operands -> 2.
- DIV a=0xFFFFFFF9 (-7) b=2 -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1).
- DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000; REM same operands -> 0. DIVU a=5 b=0 -> 0xFFFFFFFF; REMU a=5 b=0 -> 5.
- Backpressure: hold resp_rdy=0 for 5 cycles in DONE -> resp_val stays 1, resp_msg stable, req_rdy=0. Then resp_rdy=1 -> IDLE and req_rdy=1 the next cycle.
- Reset at CALC cycle 10 of DIVU 1000/3 -> resp_val never rises for that request. Next request DIVU 9/3 -> 3.
- With LAB2_PROC_INT_DIV_FAST_EN: DIVU 3/10 -> resp_val one cycle after accept, resp_msg=0. Without the macro, the same request gives 0 after 32 CALC cycles.

Source files
------------

// File: rtl/lab2_proc_div_pkg.sv
// rtl/lab2_proc_div_pkg.sv - shared function codes, FSM states and counter sizing for the divider
package lab2_proc_div_pkg;

    typedef enum logic [1:0] {
        DIV_FN_DIV  = 2'd0,
        DIV_FN_DIVU = 2'd1,
        DIV_FN_REM  = 2'd2,
        DIV_FN_REMU = 2'd3
    } div_fn_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DIV_NBITS = 32;

    // Counter must hold p_nbits itself, hence the +1.
    function automatic int div_cnt_width(input int nbits);
        return $clog2(nbits + 1);
    endfunction

    localparam int DIV_CNT_W = div_cnt_width(DIV_NBITS);

endpackage

// File: rtl/lab2_proc_int_div_dpath.sv
// rtl/lab2_proc_int_div_dpath.sv - restoring divider datapath: operands, remainder/quotient, counter, sign fix-up
// Optional early-out results when LAB2_PROC_INT_DIV_FAST_EN is defined.
module lab2_proc_int_div_dpath
    import lab2_proc_div_pkg::*;
#(
    parameter int p_nbits = DIV_NBITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [1:0]         fn_i,
    input  logic [p_nbits-1:0] a_i,
    input  logic [p_nbits-1:0] b_i,
    output logic               cnt_last_o,
    output logic               fast_o,
    output logic [p_nbits-1:0] result_o
);

    localparam int CW = div_cnt_width(p_nbits);
    localparam logic [CW-1:0] CNT_INIT = CW'(p_nbits);

    div_fn_e            fn_in;
    logic               in_signed;
    logic               a_neg;
    logic               b_neg;
    logic [p_nbits-1:0] a_mag;
    logic [p_nbits-1:0] b_mag;

    div_fn_e            fn_q;
    logic [p_nbits-1:0] quo_q;
    logic [p_nbits-1:0] rem_q;
    logic [p_nbits-1:0] dvsr_q;
    logic [p_nbits-1:0] result_q;
    logic [CW-1:0]      cnt_q;
    logic               neg_quo_q;
    logic               neg_rem_q;
    logic               bzero_q;

    logic [p_nbits:0]   rem_sh;
    logic [p_nbits:0]   trial;
    logic [p_nbits-1:0] quo_d;
    logic [p_nbits-1:0] rem_d;
    logic [p_nbits-1:0] quo_fix;
    logic [p_nbits-1:0] rem_fix;
    logic [p_nbits-1:0] step_res;
    logic               q_is_rem;

    always_comb begin
        fn_in     = div_fn_e'(fn_i);
        in_signed = (fn_in == DIV_FN_DIV) || (fn_in == DIV_FN_REM);
        a_neg     = in_signed && a_i[p_nbits-1];
        b_neg     = in_signed && b_i[p_nbits-1];
        a_mag     = a_neg ? -a_i : a_i;
        b_mag     = b_neg ? -b_i : b_i;
    end

    // One restoring step; the remainder stays below the divisor so trial fits p_nbits when non-negative.
    always_comb begin
        rem_sh   = {rem_q, quo_q[p_nbits-1]};
        trial    = rem_sh - {1'b0, dvsr_q};
        quo_d    = {quo_q[p_nbits-2:0], ~trial[p_nbits]};
        rem_d    = trial[p_nbits] ? rem_sh[p_nbits-1:0] : trial[p_nbits-1:0];
        quo_fix  = neg_quo_q ? -quo_d : quo_d;
        rem_fix  = neg_rem_q ? -rem_d : rem_d;
        q_is_rem = (fn_q == DIV_FN_REM) || (fn_q == DIV_FN_REMU);
        // A zero divisor yields all-ones naturally, but the sign flip for DIV would spoil it.
        step_res = q_is_rem ? rem_fix : (bzero_q ? '1 : quo_fix);
    end

`ifdef LAB2_PROC_INT_DIV_FAST_EN
    localparam logic [p_nbits-1:0] MOST_NEG = {1'b1, {(p_nbits-1){1'b0}}};

    logic               in_rem;
    logic               bzero_in;
    logic               ovf_in;
    logic [p_nbits-1:0] fast_res;

    always_comb begin
        in_rem   = (fn_in == DIV_FN_REM) || (fn_in == DIV_FN_REMU);
        bzero_in = (b_i == '0);
        ovf_in   = in_signed && (a_i == MOST_NEG) && (b_i == '1);
        fast_o   = bzero_in || ovf_in || (a_mag < b_mag);
        if (bzero_in) begin
            fast_res = in_rem ? a_i : '1;
        end else if (ovf_in) begin
            fast_res = in_rem ? '0 : a_i;
        end else begin
            fast_res = in_rem ? a_i : '0;
        end
    end
`else
    assign fast_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            fn_q      <= DIV_FN_DIV;
            quo_q     <= '0;
            rem_q     <= '0;
            dvsr_q    <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
        end else if (load_i) begin
            fn_q      <= fn_in;
            quo_q     <= a_mag;
            rem_q     <= '0;
            dvsr_q    <= b_mag;
            cnt_q     <= CNT_INIT;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            bzero_q   <= (b_i == '0);
`ifdef LAB2_PROC_INT_DIV_FAST_EN
            if (fast_o) begin
                result_q <= fast_res;
            end
`endif
        end else if (step_i) begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                result_q <= step_res;
            end
        end
    end

    assign cnt_last_o = (cnt_q == CW'(1));
    assign result_o   = result_q;

endmodule

// File: rtl/lab2_proc_int_div_unit.sv
// rtl/lab2_proc_int_div_unit.sv - iterative DIV/DIVU/REM/REMU unit with val/rdy request and response
// Early-out path to DONE enabled by LAB2_PROC_INT_DIV_FAST_EN (handled in the datapath).
module lab2_proc_int_div_unit
    import lab2_proc_div_pkg::*;
#(
    parameter int p_nbits = DIV_NBITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic [1:0]         req_fn,
    input  logic [p_nbits-1:0] req_a,
    input  logic [p_nbits-1:0] req_b,
    output logic               resp_val,
    input  logic               resp_rdy,
    output logic [p_nbits-1:0] resp_msg
);

    div_state_e state_q;
    div_state_e state_d;
    logic       load;
    logic       step;
    logic       cnt_last;
    logic       fast;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        req_rdy  = 1'b0;
        resp_val = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
        case (state_q)
            IDLE: begin
                req_rdy = 1'b1;
                if (req_val) begin
                    load    = 1'b1;
                    state_d = fast ? DONE : CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                resp_val = 1'b1;
                if (resp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    lab2_proc_int_div_dpath #(
        .p_nbits (p_nbits)
    ) u_dpath (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load),
        .step_i     (step),
        .fn_i       (req_fn),
        .a_i        (req_a),
        .b_i        (req_b),
        .cnt_last_o (cnt_last),
        .fast_o     (fast),
        .result_o   (resp_msg)
    );

endmodule

// File: tb/tb_lab2_proc_int_div_unit.sv
// tb/tb_lab2_proc_int_div_unit.sv - directed self-checking bench with a per-cycle arithmetic model
module tb_lab2_proc_int_div_unit;

    localparam int NB = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_val = 1'b0;
    logic          req_rdy;
    logic [1:0]    req_fn = 2'd0;
    logic [NB-1:0] req_a = '0;
    logic [NB-1:0] req_b = '0;
    logic          resp_val;
    logic          resp_rdy = 1'b0;
    logic [NB-1:0] resp_msg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lab2_proc_int_div_unit #(.p_nbits(NB)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_fn   (req_fn),
        .req_a    (req_a),
        .req_b    (req_b),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_msg (resp_msg)
    );

    function automatic logic [NB-1:0] ref_result(input logic [1:0] fn, input logic [NB-1:0] a, input logic [NB-1:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (fn)
            2'd0:    if (b == 0) return '1; else if (ovf) return a; else return $signed(a) / $signed(b);
            2'd1:    if (b == 0) return '1; else return a / b;
            2'd2:    if (b == 0) return a; else if (ovf) return '0; else return $signed(a) % $signed(b);
            default: if (b == 0) return a; else return a % b;
        endcase
    endfunction

    function automatic bit ref_fast(input logic [1:0] fn, input logic [NB-1:0] a, input logic [NB-1:0] b);
        bit en;
        bit sgn;
        logic [NB-1:0] ma;
        logic [NB-1:0] mb;
`ifdef LAB2_PROC_INT_DIV_FAST_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        sgn = !fn[0];
        ma  = (sgn && a[NB-1]) ? -a : a;
        mb  = (sgn && b[NB-1]) ? -b : b;
        return en && ((b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || (ma < mb));
    endfunction

    task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model state predicts DUT outputs after each rising edge; sampled on the falling edge.
    bit            armed = 1'b0;
    bit            m_busy = 1'b0;
    int            m_wait = 0;
    logic [NB-1:0] m_msg = '0;

    always @(negedge clk) begin
        if (armed) begin
            check("cyc req_rdy", {31'b0, req_rdy}, {31'b0, !m_busy});
            check("cyc resp_val", {31'b0, resp_val}, {31'b0, (m_busy && m_wait == 0)});
            if (m_busy && m_wait == 0) check("cyc resp_msg", resp_msg, m_msg);
        end
        if (reset) begin
            armed  = 1'b1;
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (req_val) begin
                m_busy = 1'b1;
                m_msg  = ref_result(req_fn, req_a, req_b);
                m_wait = ref_fast(req_fn, req_a, req_b) ? 0 : NB;
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (resp_rdy) begin
            m_busy = 1'b0;
        end
    end

    task automatic accept(input logic [1:0] fn, input logic [NB-1:0] a, input logic [NB-1:0] b);
        int n;
        req_fn  = fn;
        req_a   = a;
        req_b   = b;
        req_val = 1'b1;
        n = 0;
        while (!req_rdy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        req_val = 1'b0;
        req_fn  = 2'($urandom);
        req_a   = $urandom;
        req_b   = $urandom;
    endtask

    task automatic run(input string name, input logic [1:0] fn, input logic [NB-1:0] a,
                       input logic [NB-1:0] b, input logic [NB-1:0] exp, input int hold);
        int lat;
        accept(fn, a, b);
        lat = 0;
        while (!resp_val && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, 32'(lat), ref_fast(fn, a, b) ? 32'd0 : 32'(NB));
        check({name, " msg"}, resp_msg, exp);
        repeat (hold) begin
            @(posedge clk); #1;
            check({name, " stall val"}, {31'b0, resp_val}, 32'd1);
            check({name, " stall msg"}, resp_msg, exp);
            check({name, " stall rdy"}, {31'b0, req_rdy}, 32'd0);
        end
        resp_rdy = 1'b1;
        @(posedge clk); #1;
        resp_rdy = 1'b0;
        check({name, " idle rdy"}, {31'b0, req_rdy}, 32'd1);
        check({name, " idle val"}, {31'b0, resp_val}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;

        check("pin divu", ref_result(2'd1, 32'd100, 32'd7), 32'd14);
        check("pin rem", ref_result(2'd2, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        check("pin div ovf", ref_result(2'd0, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

        repeat (3) @(posedge clk);
        #1;
        check("reset req_rdy", {31'b0, req_rdy}, 32'd1);
        check("reset resp_val", {31'b0, resp_val}, 32'd0);
        check("reset resp_msg", resp_msg, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run("divu 100/7",   2'd1, 32'd100, 32'd7, 32'd14, 0);
        run("remu 100/7",   2'd3, 32'd100, 32'd7, 32'd2, 0);
        run("div -7/2",     2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        run("rem -7/2",     2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
        run("div ovf",      2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run("rem ovf",      2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
        run("divu 5/0",     2'd1, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        run("remu 5/0",     2'd3, 32'd5, 32'd0, 32'd5, 0);
        run("div 5/0",      2'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        run("rem -5/0",     2'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 0);
        run("div 100/-7",   2'd0, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 0);
        run("rem 100/-7",   2'd2, 32'd100, 32'hFFFF_FFF9, 32'd2, 0);
        run("rem -100/7",   2'd2, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 0);
        run("divu max/1",   2'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 0);
        run("divu big",     2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
        run("remu big",     2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run("backpressure", 2'd1, 32'd1000, 32'd3, 32'd333, 5);

        accept(2'd1, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen = seen | resp_val;
        end
        check("reset drops resp", {31'b0, seen}, 32'd0);
        check("reset idle rdy", {31'b0, req_rdy}, 32'd1);

        run("divu 9/3",     2'd1, 32'd9, 32'd3, 32'd3, 0);
        run("divu 3/10",    2'd1, 32'd3, 32'd10, 32'd0, 0);
        run("div -3/10",    2'd0, 32'hFFFF_FFFD, 32'd10, 32'd0, 1);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
